imem_loader: RTL

// - Program-load front end for the pipelined core: accepts a framed byte stream (valid/ready), writes it

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared constants and types.
// State encoding and memory geometry for the program loader.
package imem_loader_pkg;

  localparam int MEM_BYTES = 128;
  localparam int ADDR_SIZE = 7;
  localparam int MAX_INST  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  // Byte address of the last instruction byte for a frame of n words.
  // n==32 gives 0-1, which lands on 127 in 7 bits.
  function automatic logic [ADDR_SIZE-1:0] last_addr(
    input logic [4:0] n
  );
    logic [ADDR_SIZE-1:0] a;
    a = {n, 2'b00};
    return a - 7'd1;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader stream and memory write bus.
// Master side feeds bytes and observes writes; slave is the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic                 s_valid;
  logic [7:0]           s_data;
  logic                 s_ready;
  logic                 mem_wr_en;
  logic [ADDR_SIZE-1:0] mem_wr_addr;
  logic [7:0]           mem_wr_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  mem_wr_en,
    input  mem_wr_addr,
    input  mem_wr_data
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output mem_wr_en,
    output mem_wr_addr,
    output mem_wr_data
  );

endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream into instruction memory.
// Frame is [N][4N bytes][XOR]; cpu_en is released on a good checksum.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         abort,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         cpu_en,
  output logic [5:0]   inst_count
);

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_SIZE-1:0] r_cnt;
  logic [7:0]           r_csum;
  logic [5:0]           r_n;
  logic                 r_wr_en;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [7:0]           r_wr_data;

  logic w_busy;
  logic w_hs;
  logic w_last;
  logic w_bad_n;
  logic w_clear;
  logic w_wr;

  assign w_busy = (r_state == ST_HDR)
               || (r_state == ST_DATA)
               || (r_state == ST_CSUM);
  assign w_hs    = bus.s_valid & w_busy;
  assign w_last  = (r_cnt == last_addr(r_n[4:0]));
  assign w_bad_n = (bus.s_data == 8'd0)
                || (bus.s_data > 8'(MAX_INST));
  assign w_clear = start & ~abort
                 & ((r_state == ST_IDLE)
                 || (r_state == ST_DONE)
                 || (r_state == ST_ERR));
  assign w_wr    = w_hs & ~abort & (r_state == ST_DATA);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: abort overrides all stream activity.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) w_next = ST_HDR;
        ST_HDR:
          if (w_hs) w_next = w_bad_n ? ST_ERR : ST_DATA;
        ST_DATA:
          if (w_hs && w_last) w_next = ST_CSUM;
        ST_CSUM:
          if (w_hs)
            w_next = (bus.s_data == r_csum) ? ST_DONE : ST_ERR;
        ST_DONE: if (start) w_next = ST_HDR;
        ST_ERR:  if (start) w_next = ST_HDR;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Counter, checksum and captured N.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt  <= '0;
      r_csum <= '0;
      r_n    <= '0;
    end else if (w_clear) begin
      r_cnt  <= '0;
      r_csum <= '0;
      r_n    <= '0;
    end else if (w_hs && !abort) begin
      if (r_state == ST_HDR) r_n <= bus.s_data[5:0];
      if (r_state == ST_DATA) begin
        r_csum <= r_csum ^ bus.s_data;
        if (!w_last) r_cnt <= r_cnt + 7'd1;
      end
    end
  end

  // Registered write port, one cycle behind the handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_cnt;
        r_wr_data <= bus.s_data;
      end
    end
  end

  assign bus.s_ready     = w_busy;
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_wr_addr = r_wr_addr;
  assign bus.mem_wr_data = r_wr_data;

  assign busy       = w_busy;
  assign done       = (r_state == ST_DONE);
  assign cpu_en     = (r_state == ST_DONE);
  assign err        = (r_state == ST_ERR);
  assign inst_count = r_n;

endmodule
